leiwand_rv32_bus_master: RTL and testbench

Single-outstanding pipelined-Wishbone bus master that sits between the rv32 core's load/store/fetch logic and the on-chip RAM slave. It takes one core request at a time, checks alignment, drives the `cyc`/`stb` handshake with the one-cycle strobe the RAM slave requires, and returns read data with a one-cycle completion pulse. It holds an optional ack watchdog.

---
 rtl/leiwand_rv32_bus_master.sv | 140 ++++++++++++++
 tb/tb_leiwand_rv32_bus_master.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_bus_master.sv
// Single-outstanding pipelined-Wishbone master between the rv32 core and the on-chip RAM.
// Optional ack watchdog is compiled in with `define LEIWAND_BUS_TIMEOUT_EN.
module leiwand_rv32_bus_master #(
  parameter int MEM_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic [MEM_WIDTH-1:0] i_req_addr,
  input  logic [MEM_WIDTH-1:0] i_req_dat,
  input  logic                 i_req_we,
  input  logic [2:0]           i_req_size,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [MEM_WIDTH-1:0] o_rdata,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [MEM_WIDTH-1:0] o_wb_addr,
  output logic [MEM_WIDTH-1:0] o_wb_dat,
  output logic [2:0]           o_wb_size,
  input  logic [MEM_WIDTH-1:0] i_wb_dat,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, ERR} state_t;

  state_t               r_state;
  logic                 r_done;
  logic                 r_err;
  logic [MEM_WIDTH-1:0] r_rdata;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_we;
  logic [MEM_WIDTH-1:0] r_addr;
  logic [MEM_WIDTH-1:0] r_dat;
  logic [2:0]           r_size;
  logic                 w_misaligned;

`ifdef LEIWAND_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  // Sizes other than 1, 2 and 4 bytes are rejected like a misaligned access.
  always_comb begin
    w_misaligned = 1'b0;
    case (i_req_size)
      3'd1:    w_misaligned = 1'b0;
      3'd2:    w_misaligned = i_req_addr[0];
      3'd4:    w_misaligned = |i_req_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_size  <= '0;
`ifdef LEIWAND_BUS_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // With stb low, stall only reflects the slave being busy or initialising.
          if (i_req && !i_wb_stall) begin
            r_addr <= i_req_addr;
            r_dat  <= i_req_dat;
            r_we   <= i_req_we;
            r_size <= i_req_size;
            if (w_misaligned) begin
              r_state <= ERR;
            end else begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_state <= STROBE;
            end
          end
        end
        STROBE: begin
          r_stb   <= 1'b0;
          r_state <= WAIT_ACK;
`ifdef LEIWAND_BUS_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        WAIT_ACK: begin
          if (i_wb_ack) begin
            if (!r_we) r_rdata <= i_wb_dat;
            r_done  <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= IDLE;
`ifdef LEIWAND_BUS_TIMEOUT_EN
          end else if (r_cnt == CNT_LAST) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        ERR: begin
          r_done  <= 1'b1;
          r_err   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_rdata   = r_rdata;
  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_we;
  assign o_wb_addr = r_addr;
  assign o_wb_dat  = r_dat;
  assign o_wb_size = r_size;

endmodule

// File: tb/tb_leiwand_rv32_bus_master.sv
// Scoreboard bench for leiwand_rv32_bus_master against a small RAM slave model
// whose ack arrives two edges after the strobe edge.
module tb_leiwand_rv32_bus_master;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req;
  logic [31:0] reqAddr;
  logic [31:0] reqDat;
  logic        reqWe;
  logic [2:0]  reqSize;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        wbCyc, wbStb, wbWe;
  logic [31:0] wbAddr, wbDat, wbRdat;
  logic [2:0]  wbSize;
  logic        wbAck, wbStall;

  logic        initStall;
  logic        noAck;
  logic        pending;
  logic [31:0] mem [16];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] model [16];
  logic [31:0] lastRdata;
  int          compared;
  int          mismatched;

  always #5 clk = ~clk;

  leiwand_rv32_bus_master dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_req      (req),
    .i_req_addr (reqAddr),
    .i_req_dat  (reqDat),
    .i_req_we   (reqWe),
    .i_req_size (reqSize),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .o_wb_cyc   (wbCyc),
    .o_wb_stb   (wbStb),
    .o_wb_we    (wbWe),
    .o_wb_addr  (wbAddr),
    .o_wb_dat   (wbDat),
    .o_wb_size  (wbSize),
    .i_wb_dat   (wbRdat),
    .i_wb_ack   (wbAck),
    .i_wb_stall (wbStall)
  );

  // RAM slave: stalls while initialising or while stb is high, acks one edge after it saw stb.
  assign wbStall = initStall | wbStb;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pending <= 1'b0;
      wbAck   <= 1'b0;
      wbRdat  <= '0;
    end else begin
      pending <= wbStb;
      wbAck   <= pending & ~noAck;
      if (pending && !noAck) begin
        if (wbWe) mem[wbAddr[5:2]] <= wbDat;
        else      wbRdat <= mem[wbAddr[5:2]];
      end
    end
  end

  // Drives one request (called at a negedge) and records what its completion must look like.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic [2:0] s, input bit track);
    exp_t e;
    logic mis;
    reqAddr = a;
    reqDat  = d;
    reqWe   = w;
    reqSize = s;
    req     = 1'b1;
    mis = !((s == 3'd1) || (s == 3'd2 && a[0] == 1'b0) || (s == 3'd4 && a[1:0] == 2'b00));
    if (track) begin
      e.err = mis;
      if (!mis && w)  model[a[5:2]] = d;
      if (!mis && !w) lastRdata = model[a[5:2]];
      e.rdata = lastRdata;
      sbQ.push_back(e);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    req = 1'b0; reqAddr = '0; reqDat = '0; reqWe = 1'b0; reqSize = '0;
    initStall = 1'b1;
    noAck = 1'b0;
    lastRdata = '0;
    #1;
    compared++;
    if ({wbCyc, wbStb, wbWe, done, err, busy} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {wbCyc, wbStb, wbWe, done, err, busy});
    end
    compared++;
    if ({rdata, wbAddr, wbDat, wbSize} !== 99'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got rdata=%h addr=%h dat=%h size=%0d expected all zero",
               rdata, wbAddr, wbDat, wbSize);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_stall();
    exp_t e;
    int n;
    @(negedge clk);
    applyStimulus(32'h4, 32'h1234_5678, 1'b1, 3'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({busy, wbCyc} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL stall_hold: got busy/cyc=%b expected 00", {busy, wbCyc});
      end
    end
    initStall = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) req = 1'b0;
      n++;
    end while (!done && n < 20);
    compared++;
    if (n != 4 || done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_latency: got %0d cycles (done=%b) expected 4", n, done);
    end
    if (sbQ.size() == 0) begin
      compared++; mismatched++;
      $display("[TB] FAIL stall_sb: scoreboard empty");
    end else begin
      e = sbQ.pop_front();
      compared++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        mismatched++;
        $display("[TB] FAIL stall_result: got err=%b rdata=%h expected err=%b rdata=%h", err, rdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_aligned_write();
    exp_t e;
    logic [1:0] cs [4];
    logic       dn [4];
    @(negedge clk);
    applyStimulus(32'h8, 32'hDEAD_BEEF, 1'b1, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req = 1'b0;
      cs[i] = {wbCyc, wbStb};
      dn[i] = done;
    end
    compared++;
    if ({cs[0], cs[1], cs[2], cs[3]} !== 8'b11_10_10_00) begin
      mismatched++;
      $display("[TB] FAIL write_cyc_stb: got %b expected 11101000", {cs[0], cs[1], cs[2], cs[3]});
    end
    compared++;
    if ({dn[0], dn[1], dn[2], dn[3]} !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL write_done_timing: got %b expected 0001", {dn[0], dn[1], dn[2], dn[3]});
    end
    e = sbQ.pop_front();
    compared++;
    if ({err, rdata} !== {e.err, e.rdata}) begin
      mismatched++;
      $display("[TB] FAIL write_result: got err=%b rdata=%h expected err=%b rdata=%h", err, rdata, e.err, e.rdata);
    end
    compared++;
    if (mem[2] !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL write_ram: got %h expected deadbeef", mem[2]);
    end
  endtask

  task automatic test_aligned_read();
    exp_t e;
    logic [31:0] addrs [3] = '{32'h8, 32'h9, 32'hA};
    logic [2:0]  sizes [3] = '{3'd4, 3'd1, 3'd2};
    logic [2:0]  bz;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      applyStimulus(addrs[t], 32'h0, 1'b0, sizes[t], 1'b1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) req = 1'b0;
        if (i < 3) bz[i] = busy;
      end
      compared++;
      if (bz !== 3'b111) begin
        mismatched++;
        $display("[TB] FAIL read_busy[%0d]: got %b expected 111", t, bz);
      end
      compared++;
      if ({done, wbCyc} !== 2'b10) begin
        mismatched++;
        $display("[TB] FAIL read_done[%0d]: got done/cyc=%b expected 10", t, {done, wbCyc});
      end
      e = sbQ.pop_front();
      compared++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        mismatched++;
        $display("[TB] FAIL read_result[%0d]: got err=%b rdata=%h expected err=%b rdata=%h", t, err, rdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    logic [31:0] addrs [4] = '{32'h6, 32'h5, 32'h8, 32'hC};
    logic [2:0]  sizes [4] = '{3'd4, 3'd2, 3'd3, 3'd0};
    logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      applyStimulus(addrs[t], 32'hBAD0_0000, wes[t], sizes[t], 1'b1);
      @(negedge clk);
      req = 1'b0;
      compared++;
      if ({busy, wbCyc, done} !== 3'b100) begin
        mismatched++;
        $display("[TB] FAIL mis_err_state[%0d]: got busy/cyc/done=%b expected 100", t, {busy, wbCyc, done});
      end
      @(negedge clk);
      e = sbQ.pop_front();
      compared++;
      if ({done, err, wbCyc, rdata} !== {1'b1, e.err, 1'b0, e.rdata}) begin
        mismatched++;
        $display("[TB] FAIL mis_result[%0d]: got done=%b err=%b cyc=%b rdata=%h expected done=1 err=%b cyc=0 rdata=%h",
                 t, done, err, wbCyc, rdata, e.err, e.rdata);
      end
      @(negedge clk);
      compared++;
      if ({done, err} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL mis_pulse[%0d]: got done/err=%b expected 00", t, {done, err});
      end
    end
    compared++;
    if (mem[1] !== 32'h1234_5678) begin
      mismatched++;
      $display("[TB] FAIL mis_no_write: got %h expected 12345678", mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    logic [31:0] addrs [4] = '{32'h10, 32'h14, 32'h10, 32'h14};
    logic [31:0] dats  [4] = '{32'hAAAA_5555, 32'h5555_AAAA, 32'h0, 32'h0};
    logic        wes   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(addrs[t], dats[t], wes[t], 3'd4, 1'b1);
      n = 0;
      do begin
        @(negedge clk);
        if (n == 0) req = 1'b0;
        n++;
      end while (!done && n < 10);
      compared++;
      if (n != 4 || done !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_latency[%0d]: got %0d cycles expected 4", t, n);
      end
      e = sbQ.pop_front();
      compared++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        mismatched++;
        $display("[TB] FAIL b2b_result[%0d]: got err=%b rdata=%h expected err=%b rdata=%h", t, err, rdata, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit sawDone;
    @(negedge clk);
    applyStimulus(32'h10, 32'h0, 1'b0, 3'd4, 1'b0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    compared++;
    if ({wbCyc, wbStb, busy, done, rdata, wbAddr} !== 68'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_clear: got cyc=%b stb=%b busy=%b done=%b rdata=%h addr=%h expected all zero",
               wbCyc, wbStb, busy, done, rdata, wbAddr);
    end
    @(negedge clk);
    rstN = 1'b1;
    lastRdata = '0;
    sawDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    compared++;
    if (sawDone !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_no_done: got done pulse expected none");
    end
    applyStimulus(32'h8, 32'h0, 1'b0, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req = 1'b0;
    end
    e = sbQ.pop_front();
    compared++;
    if ({done, err, rdata} !== {1'b1, e.err, e.rdata}) begin
      mismatched++;
      $display("[TB] FAIL midreset_recover: got done=%b err=%b rdata=%h expected done=1 err=%b rdata=%h",
               done, err, rdata, e.err, e.rdata);
    end
  endtask

  task automatic test_watchdog();
    int n;
    bit sawDone;
    noAck = 1'b1;
    @(negedge clk);
    applyStimulus(32'h8, 32'h0, 1'b0, 3'd4, 1'b0);
`ifdef LEIWAND_BUS_TIMEOUT_EN
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) req = 1'b0;
      n++;
    end while (!done && n < 40);
    compared++;
    if (n != 18 || done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wdog_latency: got %0d cycles expected 18", n);
    end
    compared++;
    if ({err, wbCyc, rdata} !== {1'b1, 1'b0, lastRdata}) begin
      mismatched++;
      $display("[TB] FAIL wdog_result: got err=%b cyc=%b rdata=%h expected err=1 cyc=0 rdata=%h", err, wbCyc, rdata, lastRdata);
    end
    @(negedge clk);
    compared++;
    if ({done, err, busy} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL wdog_idle: got done/err/busy=%b expected 000", {done, err, busy});
    end
    noAck = 1'b0;
`else
    sawDone = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) req = 1'b0;
      if (done) sawDone = 1'b1;
    end
    compared++;
    if ({sawDone, busy, wbCyc} !== 3'b011) begin
      mismatched++;
      $display("[TB] FAIL wdog_hang: got done_seen/busy/cyc=%b expected 011", {sawDone, busy, wbCyc});
    end
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    noAck = 1'b0;
    lastRdata = '0;
`endif
    @(negedge clk);
    applyStimulus(32'h14, 32'h0, 1'b0, 3'd4, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) req = 1'b0;
      n++;
    end while (!done && n < 10);
    if (sbQ.size() != 0) begin
      exp_t e;
      e = sbQ.pop_front();
      compared++;
      if ({done, err, rdata} !== {1'b1, e.err, e.rdata}) begin
        mismatched++;
        $display("[TB] FAIL wdog_recover: got done=%b err=%b rdata=%h expected done=1 err=%b rdata=%h",
                 done, err, rdata, e.err, e.rdata);
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_stall();
    test_aligned_write();
    test_aligned_read();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    compared++;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb_drain: got %0d leftover entries expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] time limit");
  end

endmodule
